// File: rtl/hmac_chunk_pkg.sv
// Shared types and widths for the HMAC chunk verifier.
// Holds the FSM state encoding and the saturating error-counter helper.
package hmac_chunk_pkg;

  localparam int BEAT_W     = 512;
  localparam int TAG_W      = 128;
  localparam int CNT_W      = 16;
  localparam int MAX_BURSTS = 16;
  localparam int PTR_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FILL,
    ST_WAIT_TAG,
    ST_DRAIN,
    ST_ERR
  } state_e;

  // Increments, but sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/chunk_buffer.sv
// Holds one chunk's beats until its tag is confirmed.
// Single write port, asynchronous read port, no reset on the storage.
module chunk_buffer
  import hmac_chunk_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BEAT_W-1:0] rd_data
);

  logic [BEAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hmac_chunk_verifier.sv
// Forwards a chunk to an HMAC engine while buffering it, then releases the
// buffered beats only if the engine's tag equals the tag supplied with the chunk.
//
// state       | meaning
// ST_IDLE     | ready for a new chunk request, tag captured on accept
// ST_START    | asking the engine to begin a new MAC
// ST_FILL     | beats pass through to the engine and into the buffer
// ST_WAIT_TAG | waiting for the engine's computed tag
// ST_DRAIN    | tag matched, buffered beats go out in order
// ST_ERR      | tag mismatched, one-cycle error pulse, chunk discarded
module hmac_chunk_verifier
  import hmac_chunk_pkg::*;
#(
  parameter int DATA_COUNT_BURSTS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chk_val,
  output logic              chk_rdy,
  input  logic [TAG_W-1:0]  chk_tag,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_val,
  output logic              in_rdy,
  output logic              hm_req_val,
  input  logic              hm_req_rdy,
  output logic [BEAT_W-1:0] hm_data,
  output logic              hm_data_val,
  input  logic              hm_data_rdy,
  input  logic [TAG_W-1:0]  hm_tag,
  input  logic              hm_tag_val,
  output logic              hm_tag_rdy,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_val,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              auth_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int AW = (DATA_COUNT_BURSTS > 1) ? $clog2(DATA_COUNT_BURSTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DATA_COUNT_BURSTS - 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [BEAT_W-1:0] buf_rd_data;
  logic              beat_fire;
  logic              out_fire;
  logic              tag_match;

  assign tag_match = (hm_tag == tag_q);
  assign beat_fire = hm_data_val && in_rdy;
  assign out_fire  = out_val && out_rdy;

  // Data path to the engine is a pure wire so a one-cycle rdy pulse is never missed.
  assign hm_data   = in_data;
  assign out_data  = out_val ? buf_rd_data : '0;
  assign err_count = rst_n ? err_cnt_q : '0;

  // Every handshake output is forced low while rst_n is held.
  always_comb begin
    state_d     = state_q;
    chk_rdy     = 1'b0;
    hm_req_val  = 1'b0;
    hm_data_val = 1'b0;
    in_rdy      = 1'b0;
    hm_tag_rdy  = 1'b0;
    out_val     = 1'b0;
    out_last    = 1'b0;
    auth_err    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          chk_rdy = 1'b1;
          if (chk_val) state_d = ST_START;
        end
        ST_START: begin
          hm_req_val = 1'b1;
          if (hm_req_rdy) state_d = ST_FILL;
        end
        ST_FILL: begin
          hm_data_val = in_val;
          in_rdy      = hm_data_rdy;
          if (in_val && hm_data_rdy && (wr_ptr_q == LAST_PTR)) state_d = ST_WAIT_TAG;
        end
        ST_WAIT_TAG: begin
          hm_tag_rdy = 1'b1;
          if (hm_tag_val) state_d = tag_match ? ST_DRAIN : ST_ERR;
        end
        ST_DRAIN: begin
          out_val  = 1'b1;
          out_last = (rd_ptr_q == LAST_PTR);
          if (out_rdy && (rd_ptr_q == LAST_PTR)) state_d = ST_IDLE;
        end
        ST_ERR: begin
          auth_err = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (chk_rdy && chk_val) tag_q <= chk_tag;
      if (beat_fire) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (out_fire)  rd_ptr_q <= out_last ? '0 : rd_ptr_q + PTR_W'(1);
      if (state_q == ST_ERR) begin
        err_cnt_q <= sat_inc(err_cnt_q);
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
      end
    end
  end

  chunk_buffer #(
    .DEPTH (DATA_COUNT_BURSTS),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (beat_fire),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (buf_rd_data)
  );

endmodule

// File: tb/tb_hmac_chunk_verifier.sv
// Directed and randomized bench for hmac_chunk_verifier; the bench plays the
// chunk source, the HMAC engine and the output sink.
module tb_hmac_chunk_verifier;
  import hmac_chunk_pkg::*;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              chk_val, chk_rdy;
  logic [TAG_W-1:0]  chk_tag;
  logic [BEAT_W-1:0] in_data;
  logic              in_val, in_rdy;
  logic              hm_req_val, hm_req_rdy;
  logic [BEAT_W-1:0] hm_data;
  logic              hm_data_val, hm_data_rdy;
  logic [TAG_W-1:0]  hm_tag;
  logic              hm_tag_val, hm_tag_rdy;
  logic [BEAT_W-1:0] out_data;
  logic              out_val, out_rdy, out_last, auth_err;
  logic [CNT_W-1:0]  err_count;

  always #5 clk = ~clk;

  hmac_chunk_verifier #(.DATA_COUNT_BURSTS(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .chk_val(chk_val), .chk_rdy(chk_rdy), .chk_tag(chk_tag),
    .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .hm_req_val(hm_req_val), .hm_req_rdy(hm_req_rdy),
    .hm_data(hm_data), .hm_data_val(hm_data_val), .hm_data_rdy(hm_data_rdy),
    .hm_tag(hm_tag), .hm_tag_val(hm_tag_val), .hm_tag_rdy(hm_tag_rdy),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .out_last(out_last),
    .auth_err(auth_err), .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;
  int n_outval = 0;
  int n_autherr = 0;
  logic [BEAT_W-1:0] beats [N];
  logic [CNT_W-1:0]  exp_err;
  logic [TAG_W-1:0]  tag_a5;

  always @(negedge clk) begin
    #2;
    if (out_val === 1'b1) n_outval++;
    if (auth_err === 1'b1) n_autherr++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] rand512();
    logic [BEAT_W-1:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [TAG_W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Runs one chunk; enters and leaves just after a falling edge.
  task automatic run_chunk(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] eng_tag,
                           input bit stall, input int bp, input int abort_after);
    bit match;
    int cyc, k, j, ov0, ae0;
    bit have_held, prev_fire;
    logic [BEAT_W-1:0] held_d;
    logic held_l;
    match = (tag == eng_tag);
    ov0 = n_outval;
    ae0 = n_autherr;

    chk_val = 1'b1; chk_tag = tag; cyc = 0;
    while (1) begin
      #1;
      if (chk_rdy === 1'b1 || cyc >= 20) break;
      @(negedge clk); cyc++;
    end
    chk("chk_accept", chk_rdy, 1'b1);
    @(negedge clk);

    // Busy: spurious chunk request, tag and beat must all be refused.
    chk_tag = ~tag; hm_req_rdy = 1'b1; hm_tag_val = 1'b1; hm_tag = eng_tag;
    in_val = 1'b1; in_data = rand512();
    #1;
    chk("busy_chk_rdy", chk_rdy, 1'b0);
    chk("early_tag_rdy", hm_tag_rdy, 1'b0);
    chk("early_in_rdy", in_rdy, 1'b0);
    cyc = 0;
    while (hm_req_val !== 1'b1 && cyc < 20) begin @(negedge clk); #1; cyc++; end
    chk("hm_req_val", hm_req_val, 1'b1);
    @(negedge clk);
    chk_val = 1'b0; hm_req_rdy = 1'b0; hm_tag_val = 1'b0;

    k = 0; cyc = 0;
    while (k < N && cyc < 100) begin
      in_val = 1'b1; in_data = beats[k];
      hm_data_rdy = stall ? (cyc % 3 == 2) : 1'b1;
      #1;
      chk("in_rdy_eq_hm_rdy", in_rdy, hm_data_rdy);
      chk("hm_data_fwd", hm_data, beats[k]);
      chk("hm_data_val", hm_data_val, 1'b1);
      if (in_rdy === 1'b1 && hm_data_val === 1'b1) k++;
      @(negedge clk); cyc++;
      if (abort_after >= 0 && k == abort_after) break;
    end
    in_val = 1'b0; hm_data_rdy = 1'b0;

    if (abort_after >= 0) begin
      rst_n = 1'b0; in_val = 1'b1;
      #1;
      chk("rst_chk_rdy", chk_rdy, 1'b0);
      chk("rst_in_rdy", in_rdy, 1'b0);
      chk("rst_hm_data_val", hm_data_val, 1'b0);
      chk("rst_err_count", err_count, 16'h0);
      @(negedge clk);
      rst_n = 1'b1; in_val = 1'b0;
      #1;
      exp_err = '0;
      chk("post_rst_chk_rdy", chk_rdy, 1'b1);
      chk("abort_no_out_val", n_outval - ov0, 0);
      chk("abort_no_auth_err", n_autherr - ae0, 0);
      chk("post_rst_err_count", err_count, exp_err);
      @(negedge clk);
      return;
    end
    chk("beats_forwarded", k, N);

    hm_tag_val = 1'b1; hm_tag = eng_tag; cyc = 0;
    while (1) begin
      #1;
      if (hm_tag_rdy === 1'b1 || cyc >= 20) break;
      @(negedge clk); cyc++;
    end
    chk("hm_tag_rdy", hm_tag_rdy, 1'b1);
    @(negedge clk);
    hm_tag_val = 1'b0; hm_tag = rand128();

    if (match) begin
      j = 0; cyc = 0; have_held = 1'b0; prev_fire = 1'b0;
      while (j < N && cyc < 100) begin
        out_rdy = (cyc >= bp);
        #1;
        if (cyc == 0) begin
          chk("out_val_latency", out_val, 1'b1);
          chk("no_auth_err", auth_err, 1'b0);
        end
        if (have_held && !prev_fire) begin
          chk("bp_data_stable", out_data, held_d);
          chk("bp_last_stable", out_last, held_l);
        end
        held_d = out_data; held_l = out_last; have_held = 1'b1; prev_fire = 1'b0;
        if (out_val === 1'b1 && out_rdy === 1'b1) begin
          chk("out_data", out_data, beats[j]);
          chk("out_last", out_last, (j == N - 1));
          j++; prev_fire = 1'b1;
        end
        @(negedge clk); cyc++;
      end
      out_rdy = 1'b0;
      #1;
      chk("beats_out", j, N);
      chk("drain_done_out_val", out_val, 1'b0);
      chk("drain_done_chk_rdy", chk_rdy, 1'b1);
      chk("match_no_err_pulse", n_autherr - ae0, 0);
      chk("match_err_count", err_count, exp_err);
    end else begin
      out_rdy = 1'b1;
      #1;
      chk("auth_err_pulse", auth_err, 1'b1);
      chk("err_out_val", out_val, 1'b0);
      @(negedge clk);
      #1;
      exp_err = (exp_err == 16'hFFFF) ? exp_err : exp_err + 16'd1;
      chk("auth_err_one_cycle", auth_err, 1'b0);
      chk("err_chk_rdy", chk_rdy, 1'b1);
      chk("err_count", err_count, exp_err);
      chk("err_pulse_count", n_autherr - ae0, 1);
      chk("fail_no_out_val", n_outval - ov0, 0);
      out_rdy = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [TAG_W-1:0] t, e;
    rst_n = 1'b0; chk_val = 1'b1; chk_tag = '0; in_data = '0; in_val = 1'b1;
    hm_req_rdy = 1'b1; hm_data_rdy = 1'b1; hm_tag = '0; hm_tag_val = 1'b1; out_rdy = 1'b1;
    exp_err = '0;
    tag_a5 = {16{8'hA5}};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_chk_rdy0", chk_rdy, 1'b0);
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_auth_err", auth_err, 1'b0);
    chk("rst_hm_req_val", hm_req_val, 1'b0);
    chk("rst_hm_data_val", hm_data_val, 1'b0);
    chk("rst_hm_tag_rdy", hm_tag_rdy, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_err_count0", err_count, 16'h0);
    @(negedge clk);
    rst_n = 1'b1; chk_val = 1'b0; in_val = 1'b0; hm_req_rdy = 1'b0;
    hm_data_rdy = 1'b0; hm_tag_val = 1'b0; out_rdy = 1'b0;
    #1;
    chk("rst_release_chk_rdy", chk_rdy, 1'b1);
    @(negedge clk);

    // Basic match with beats 1 and 2.
    beats[0] = 512'h1; beats[1] = 512'h2;
    run_chunk(tag_a5, tag_a5, 1'b0, 0, -1);
    // Bit-0 mismatch.
    run_chunk(tag_a5, tag_a5 ^ 128'h1, 1'b0, 0, -1);
    // Output back-pressure for 5 cycles.
    for (int i = 0; i < N; i++) beats[i] = rand512();
    run_chunk(tag_a5, tag_a5, 1'b0, 5, -1);
    // Engine accepts only every third cycle.
    for (int i = 0; i < N; i++) beats[i] = rand512();
    run_chunk(tag_a5, tag_a5, 1'b1, 0, -1);
    // Reset after first beat, then a clean chunk.
    for (int i = 0; i < N; i++) beats[i] = rand512();
    run_chunk(tag_a5, tag_a5, 1'b0, 0, 1);
    for (int i = 0; i < N; i++) beats[i] = rand512();
    run_chunk(tag_a5, tag_a5, 1'b0, 1, -1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) beats[i] = rand512();
      t = rand128();
      e = ($urandom_range(1, 0) == 1) ? t : (t ^ (128'h1 << $urandom_range(127, 0)));
      run_chunk(t, e, 1'($urandom_range(1, 0)), $urandom_range(3, 0), -1);
    end

    // Saturation: preload near the top, then three mismatches.
    force dut.err_cnt_q = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    exp_err = 16'hFFFE;
    #1;
    chk("preload", err_count, exp_err);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) beats[i] = rand512();
      t = rand128();
      run_chunk(t, ~t, 1'b0, 0, -1);
    end
    #1;
    chk("saturated", err_count, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
